bcd_timer_gen: RTL and testbench

BCD_TIMER_GEN -- requirements
Module: bcd_timer_gen

---
 rtl/bcd_timer_gen.sv | 133 +++++++++++++
 tb/tb_bcd_timer_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_gen.sv
// BCD countdown timer (minutes:seconds) with digit shift-in loading and a done pulse.
// Optional +30 s button logic is compiled in when TIMER_ADD30_EN is defined.
module bcd_timer_gen #(
  parameter int MIN_DIGITS = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    en,
  input  logic                    tick,
`ifdef TIMER_ADD30_EN
  input  logic                    add30,
`endif
  input  logic [3:0]              data,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    done,
  output logic                    running
);

  localparam int MW = 4 * MIN_DIGITS;

  logic [3:0]      ones_q, ones_d;
  logic [3:0]      tens_q, tens_d;
  logic [MW-1:0]   mins_q, mins_d;
  logic            done_q, done_d;
  logic [MW+3:0]   shift_word;
  logic [MW-1:0]   mins_dec;
  logic [MIN_DIGITS-1:0] borrow_c;
  logic            add_req;
  logic            do_count;

`ifdef TIMER_ADD30_EN
  logic [MW-1:0]   mins_inc;
  logic [MIN_DIGITS:0] carry_c;
  logic [4:0]      tens_sum;

  assign add_req    = load & add30;
  assign carry_c[0] = 1'b1;
  assign tens_sum   = {1'b0, tens_q} + 5'd3;
`else
  assign add_req = 1'b0;
`endif

  assign borrow_c[0] = 1'b1;
  assign shift_word  = {mins_q, tens_q};

  // Per-digit BCD borrow (decrement) and carry (increment) chains across the minute digits.
  generate
    for (genvar gi = 0; gi < MIN_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = mins_q[4*gi +: 4];
      assign mins_dec[4*gi +: 4] = !borrow_c[gi]   ? digit :
                                   (digit == 4'd0) ? 4'd9  : digit - 4'd1;
      if (gi < MIN_DIGITS - 1) begin : g_borrow
        assign borrow_c[gi+1] = borrow_c[gi] & (digit == 4'd0);
      end
`ifdef TIMER_ADD30_EN
      assign mins_inc[4*gi +: 4] = !carry_c[gi]    ? digit :
                                   (digit == 4'd9) ? 4'd0  : digit + 4'd1;
      assign carry_c[gi+1] = carry_c[gi] & (digit == 4'd9);
`endif
    end
  endgenerate

  assign zero     = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == '0);
  assign running  = ~en & load & ~zero;
  assign do_count = load & ~en & tick & ~zero & ~add_req;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    mins_d = mins_q;
    done_d = 1'b0;
    if (!load) begin
      if (data <= 4'd9) begin
        mins_d = shift_word[MW-1:0];
        tens_d = ones_q;
        ones_d = data;
      end
`ifdef TIMER_ADD30_EN
    end else if (add_req) begin
      if (tens_sum >= 5'd6) begin
        // Carry into minutes; an all-9 minute field cannot absorb it, so clamp.
        if (carry_c[MIN_DIGITS]) begin
          mins_d = {MIN_DIGITS{4'd9}};
          tens_d = 4'd5;
          ones_d = 4'd9;
        end else begin
          mins_d = mins_inc;
          tens_d = 4'(tens_sum - 5'd6);
        end
      end else begin
        tens_d = tens_sum[3:0];
      end
`endif
    end else if (do_count) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        tens_d = tens_q - 4'd1;
        ones_d = 4'd9;
      end else begin
        mins_d = mins_dec;
        tens_d = 4'd5;
        ones_d = 4'd9;
      end
      done_d = (ones_d == 4'd0) && (tens_d == 4'd0) && (mins_d == '0);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      mins_q <= '0;
      done_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      mins_q <= mins_d;
      done_q <= done_d;
    end
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign mins     = mins_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_timer_gen.sv
// Bench for bcd_timer_gen: one and three minute-digit instances share stimulus and are
// checked every cycle against an integer minutes/seconds model, plus literal checkpoints.
module tb_bcd_timer_gen;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b1;
  logic        en = 1'b1;
  logic        tick = 1'b0;
  logic        add30 = 1'b0;
  logic [3:0]  data = 4'd0;

  logic [3:0]  so1, st1, mn1, so3, st3;
  logic [11:0] mn3;
  logic        z1, d1, r1, z3, d3, r3;

`ifdef TIMER_ADD30_EN
  localparam bit ADD30_BUILD = 1'b1;
`else
  localparam bit ADD30_BUILD = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  bcd_timer_gen #(.MIN_DIGITS(1)) dut1 (
    .clk(clk), .clr(clr), .load(load), .en(en), .tick(tick),
`ifdef TIMER_ADD30_EN
    .add30(add30),
`endif
    .data(data), .sec_ones(so1), .sec_tens(st1), .mins(mn1),
    .zero(z1), .done(d1), .running(r1)
  );

  bcd_timer_gen #(.MIN_DIGITS(3)) dut3 (
    .clk(clk), .clr(clr), .load(load), .en(en), .tick(tick),
`ifdef TIMER_ADD30_EN
    .add30(add30),
`endif
    .data(data), .sec_ones(so3), .sec_tens(st3), .mins(mn3),
    .zero(z3), .done(d3), .running(r3)
  );

  always #5 clk = ~clk;

  // Model state: minutes as a plain integer, seconds as two (possibly unnormalised) digits.
  int m1, t1, o1, m3, t3, o3;
  bit ed1, ed3;
  int n_m1, n_t1, n_o1, n_m3, n_t3, n_o3;
  bit n_d1, n_d3;
  logic add30_eff;

  assign add30_eff = ADD30_BUILD & add30;

  function automatic void model_next(input int m, input int t, input int o, input int md,
                                     input logic l, input logic e, input logic tk,
                                     input logic a, input logic [3:0] d,
                                     output int nm, output int nt, output int no,
                                     output bit nd);
    int maxm;
    int s;
    maxm = (md == 1) ? 9 : (md == 2) ? 99 : 999;
    nm = m; nt = t; no = o; nd = 1'b0;
    if (!l) begin
      if (d <= 4'd9) begin
        nm = (m * 10 + t) % (maxm + 1);
        nt = o;
        no = int'(d);
      end
    end else if (a) begin
      s = t * 10 + o + 30;
      if (s >= 60) begin
        s = s - 60;
        if (m + 1 > maxm) begin
          nm = maxm;
          s  = 59;
        end else begin
          nm = m + 1;
        end
      end
      nt = s / 10;
      no = s % 10;
    end else if (!e && tk && (m != 0 || t != 0 || o != 0)) begin
      if (o > 0) begin
        no = o - 1;
      end else if (t > 0) begin
        nt = t - 1; no = 9;
      end else begin
        nm = m - 1; nt = 5; no = 9;
      end
      nd = (nm == 0 && nt == 0 && no == 0);
    end
  endfunction

  always_comb begin
    model_next(m1, t1, o1, 1, load, en, tick, add30_eff, data, n_m1, n_t1, n_o1, n_d1);
    model_next(m3, t3, o3, 3, load, en, tick, add30_eff, data, n_m3, n_t3, n_o3, n_d3);
  end

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m1 <= 0; t1 <= 0; o1 <= 0; ed1 <= 1'b0;
      m3 <= 0; t3 <= 0; o3 <= 0; ed3 <= 1'b0;
    end else begin
      m1 <= n_m1; t1 <= n_t1; o1 <= n_o1; ed1 <= n_d1;
      m3 <= n_m3; t3 <= n_t3; o3 <= n_o3; ed3 <= n_d3;
    end
  end

  function automatic logic [19:0] pack(input int m, input int t, input int o);
    pack = {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10), 4'(t), 4'(o)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [19:0] p1, p3;
    bit ez1, ez3;
    if (clr) begin
      p1  = pack(m1, t1, o1);
      p3  = pack(m3, t3, o3);
      ez1 = (m1 == 0 && t1 == 0 && o1 == 0);
      ez3 = (m3 == 0 && t3 == 0 && o3 == 0);
      chk("d1_digits", {20'd0, mn1, st1, so1}, {20'd0, p1[11:0]});
      chk("d1_zero", {31'd0, z1}, {31'd0, ez1});
      chk("d1_done", {31'd0, d1}, {31'd0, ed1});
      chk("d1_running", {31'd0, r1}, {31'd0, (!en && load && !ez1)});
      chk("d3_digits", {12'd0, mn3, st3, so3}, {12'd0, p3});
      chk("d3_zero", {31'd0, z3}, {31'd0, ez3});
      chk("d3_done", {31'd0, d3}, {31'd0, ed3});
      chk("d3_running", {31'd0, r3}, {31'd0, (!en && load && !ez3)});
    end
  end

  task automatic cyc(input logic l, input logic e, input logic tk, input logic a,
                     input logic [3:0] d);
    load = l; en = e; tick = tk; add30 = a; data = d;
    @(posedge clk);
    #2;
    load = 1'b1; en = 1'b1; tick = 1'b0; add30 = 1'b0; data = 4'd0;
  endtask

  task automatic ld(input logic [3:0] d);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic lit1(input string nm, input logic [11:0] exp);
    logic [19:0] p;
    p = pack(m1, t1, o1);
    chk(nm, {20'd0, mn1, st1, so1}, {20'd0, exp});
    chk({"model_", nm}, {20'd0, p[11:0]}, {20'd0, exp});
  endtask

  task automatic lit3(input string nm, input logic [19:0] exp);
    logic [19:0] p;
    p = pack(m3, t3, o3);
    chk(nm, {12'd0, mn3, st3, so3}, {12'd0, exp});
    chk({"model_", nm}, {12'd0, p}, {12'd0, exp});
  endtask

  task automatic clr_pulse();
    clr = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b1;
  endtask

  initial begin
    #1 clr = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    lit1("reset_digits", 12'h000);
    chk("reset_zero", {31'd0, z1}, 32'd1);
    chk("reset_done", {31'd0, d1}, 32'd0);
    chk("reset_running", {31'd0, r1}, 32'd0);
    en = 1'b1;
    clr = 1'b1;

    ld(4'd5); ld(4'd4); ld(4'd3);
    lit1("load_543", 12'h543);
    lit3("load_543_md3", 20'h00543);

    ticks(3);
    lit1("count_540", 12'h540);
    ticks(1);
    lit1("tens_borrow_539", 12'h539);
    ticks(6);
    lit1("count_533", 12'h533);

    ld(4'd1); ld(4'd0); ld(4'd0);
    lit1("load_100", 12'h100);
    ticks(1);
    lit1("min_borrow_059", 12'h059);

    ld(4'd0); ld(4'd0); ld(4'd1);
    lit1("load_001", 12'h001);
    ticks(1);
    lit1("reach_zero", 12'h000);
    chk("done_pulse", {31'd0, d1}, 32'd1);
    ticks(3);
    lit1("hold_zero", 12'h000);
    chk("done_after_hold", {31'd0, d1}, 32'd0);

    ld(4'd0); ld(4'd3); ld(4'd0);
    lit1("load_030", 12'h030);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    lit1("pause_030", 12'h030);
    ld(4'hC);
    lit1("bad_digit_030", 12'h030);

    ld(4'd0); ld(4'd0);
    lit1("load_to_zero", 12'h000);
    chk("no_done_on_load", {31'd0, d1}, 32'd0);

    ld(4'd7); ld(4'd5);
    ticks(1);
    lit1("unnorm_074", 12'h074);

    clr_pulse();
    ld(4'd1); ld(4'd2); ld(4'd3); ld(4'd4); ld(4'd5);
    lit3("md3_12345", 20'h12345);
    lit1("md1_345", 12'h345);
    ld(4'd6);
    lit3("md3_23456", 20'h23456);

`ifdef TIMER_ADD30_EN
    clr_pulse();
    ld(4'd0); ld(4'd4); ld(4'd5);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    lit1("add30_115", 12'h115);
    ld(4'd9); ld(4'd5); ld(4'd0);
    lit1("load_950", 12'h950);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    lit1("add30_sat", 12'h959);
    ld(4'd1); ld(4'd1); ld(4'd5);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    lit1("add30_beats_tick", 12'h145);
    ld(4'd0); ld(4'd7); ld(4'd5);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    lit1("add30_unnorm", 12'h145);
`endif

    // Asynchronous clear between edges, then counting resumes normally on a zero value.
    ld(4'd0); ld(4'd0); ld(4'd9);
    clr = 1'b0;
    #2;
    lit1("async_clr", 12'h000);
    chk("async_clr_done", {31'd0, d1}, 32'd0);
    clr = 1'b1;
    ticks(2);
    lit1("post_clr_hold", 12'h000);
    ld(4'd2);
    ticks(1);
    lit1("post_clr_count", 12'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
